// File: rtl/req_gnt_pkg.sv
// Shared constants and types for the req/gnt boundary block.
// Optional statistics counters are enabled with the REQ_GNT_STATS_EN macro.
package req_gnt_pkg;

    // Legal range for every delay parameter, in clk cycles.
    localparam int DLY_MIN = 1;
    localparam int DLY_MAX = 8;

    // Default width of the statistics counters.
    localparam int CNT_W = 16;

    // The priming counter must reach GNT_LAT + IN_DLY, at most 2*DLY_MAX.
    localparam int PRIME_W = $clog2(2 * DLY_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // True when a delay parameter is inside the supported range.
    function automatic bit dly_ok(input int dly);
        return (dly >= DLY_MIN) && (dly <= DLY_MAX);
    endfunction

endpackage

// File: rtl/req_gnt_dly_line.sv
// 1-bit shift register of DEPTH flops with synchronous active-high reset.
// Used for the req, gnt and expected-gnt pipelines of req_gnt_sync_if.
module req_gnt_dly_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_stage;

    // Shift the input in at stage 0; the output is the oldest stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's
            // old value, which is what turns this loop into a shift register.
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_stage[0] <= i_d;
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/req_gnt_sync_if.sv
// req/gnt boundary block: skews req towards the DUT, samples gnt back, and
// compares the sampled gnt with a delayed copy of req (sticky mismatch flag).
// Define REQ_GNT_STATS_EN to build the saturating toggle/error counters;
// without it both counter ports are tied to zero.
module req_gnt_sync_if
    import req_gnt_pkg::*;
#(
    parameter int OUT_DLY = 1,
    parameter int IN_DLY  = 1,
    parameter int GNT_LAT = 1,
    parameter int CNT_W   = req_gnt_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_drv_i,
    output logic             req_o,
    input  logic             gnt_i,
    output logic             gnt_smp_o,
    output logic             chk_vld_o,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] toggle_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Expected gnt lags req_o by the DUT latency plus our own sampling skew.
    localparam int EXP_DLY = GNT_LAT + IN_DLY;

    generate
        if (!dly_ok(OUT_DLY)) begin : g_bad_out_dly
            $error("req_gnt_sync_if: OUT_DLY out of range 1..8");
        end
        if (!dly_ok(IN_DLY)) begin : g_bad_in_dly
            $error("req_gnt_sync_if: IN_DLY out of range 1..8");
        end
        if (!dly_ok(GNT_LAT)) begin : g_bad_gnt_lat
            $error("req_gnt_sync_if: GNT_LAT out of range 1..8");
        end
    endgenerate

    logic               w_req_q;
    logic               w_gnt_smp;
    logic               w_exp;
    logic               w_cmp_err;
    logic [PRIME_W-1:0] r_prime_cnt;
    logic               r_chk_vld;
    logic               r_mismatch;

    req_gnt_dly_line #(.DEPTH(OUT_DLY)) u_req_line (
        .clk (clk),
        .rst (rst),
        .i_d (req_drv_i),
        .o_q (w_req_q)
    );

    req_gnt_dly_line #(.DEPTH(IN_DLY)) u_gnt_line (
        .clk (clk),
        .rst (rst),
        .i_d (gnt_i),
        .o_q (w_gnt_smp)
    );

    req_gnt_dly_line #(.DEPTH(EXP_DLY)) u_exp_line (
        .clk (clk),
        .rst (rst),
        .i_d (w_req_q),
        .o_q (w_exp)
    );

    // A checked cycle whose sampled gnt disagrees with the expected value.
    assign w_cmp_err = r_chk_vld & (w_exp ^ w_gnt_smp);

    // Count cycles after reset until the expected pipeline reflects real req_o history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime_cnt <= '0;
            r_chk_vld   <= 1'b0;
        end else if (!r_chk_vld) begin
            if (r_prime_cnt == PRIME_W'(EXP_DLY - 1)) begin
                r_chk_vld <= 1'b1;
            end
            r_prime_cnt <= r_prime_cnt + PRIME_W'(1);
        end
    end

    // Sticky mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_cmp_err) begin
            r_mismatch <= 1'b1;
        end
    end

    assign req_o      = w_req_q;
    assign gnt_smp_o  = w_gnt_smp;
    assign chk_vld_o  = r_chk_vld;
    assign mismatch_o = r_mismatch;

`ifdef REQ_GNT_STATS_EN
    logic             r_req_d;
    logic [CNT_W-1:0] r_toggle_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating counters for req_o edges and mismatching checked cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d      <= 1'b0;
            r_toggle_cnt <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_req_d <= w_req_q;
            if ((w_req_q != r_req_d) && (r_toggle_cnt != '1)) begin
                r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
            end
            if (w_cmp_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign toggle_cnt_o = r_toggle_cnt;
    assign err_cnt_o    = r_err_cnt;
`else
    assign toggle_cnt_o = '0;
    assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_req_gnt_sync_if.sv
// Bench for req_gnt_sync_if: a default instance (A) and an OUT_DLY=3/IN_DLY=2
// instance (B), each talking to an ideal 1-cycle-latency DUT model.
// Expected req_o / gnt_smp_o values are queued when stimulus is driven and
// compared on the cycle they are due.
module tb_req_gnt_sync_if;
    import req_gnt_pkg::*;

    localparam int CW    = 16;
    localparam int A_OUT = 1;
    localparam int A_IN  = 1;
    localparam int A_LAT = 1;
    localparam int B_OUT = 3;
    localparam int B_IN  = 2;
    localparam int B_LAT = 1;
`ifdef REQ_GNT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          drv_a = 1'b0;
    logic          drv_b = 1'b0;
    logic          force_a = 1'b0;
    logic          req_a, gsmp_a, vld_a, mm_a, gnt_a, dut_gnt_a;
    logic          req_b, gsmp_b, vld_b, mm_b, gnt_b, dut_gnt_b;
    logic [CW-1:0] tog_a, err_a, tog_b, err_b;

    typedef struct {
        int   due;
        int   id;
        logic exp;
    } sb_t;

    sb_t sb[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal DUTs: gnt is req delayed by one cycle; A's gnt can be forced low.
    always @(posedge clk) begin
        if (rst) begin
            dut_gnt_a <= 1'b0;
            dut_gnt_b <= 1'b0;
        end else begin
            dut_gnt_a <= req_a;
            dut_gnt_b <= req_b;
        end
    end
    assign gnt_a = force_a ? 1'b0 : dut_gnt_a;
    assign gnt_b = dut_gnt_b;

    req_gnt_sync_if #(.OUT_DLY(A_OUT), .IN_DLY(A_IN), .GNT_LAT(A_LAT), .CNT_W(CW)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .req_drv_i    (drv_a),
        .req_o        (req_a),
        .gnt_i        (gnt_a),
        .gnt_smp_o    (gsmp_a),
        .chk_vld_o    (vld_a),
        .mismatch_o   (mm_a),
        .toggle_cnt_o (tog_a),
        .err_cnt_o    (err_a)
    );

    req_gnt_sync_if #(.OUT_DLY(B_OUT), .IN_DLY(B_IN), .GNT_LAT(B_LAT), .CNT_W(CW)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .req_drv_i    (drv_b),
        .req_o        (req_b),
        .gnt_i        (gnt_b),
        .gnt_smp_o    (gsmp_b),
        .chk_vld_o    (vld_b),
        .mismatch_o   (mm_b),
        .toggle_cnt_o (tog_b),
        .err_cnt_o    (err_b)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    function automatic logic obs_of(input int id);
        case (id)
            0:       return req_a;
            1:       return gsmp_a;
            2:       return req_b;
            default: return gsmp_b;
        endcase
    endfunction

    function automatic string name_of(input int id);
        case (id)
            0:       return "a_req_o";
            1:       return "a_gnt_smp_o";
            2:       return "b_req_o";
            default: return "b_gnt_smp_o";
        endcase
    endfunction

    // Queue expectations for the drive held this cycle, advance one cycle,
    // then compare every entry that has come due.
    task automatic step();
        sb.push_back('{due: cyc + A_OUT,                 id: 0, exp: drv_a});
        sb.push_back('{due: cyc + A_OUT + A_LAT + A_IN,  id: 1, exp: drv_a});
        sb.push_back('{due: cyc + B_OUT,                 id: 2, exp: drv_b});
        sb.push_back('{due: cyc + B_OUT + B_LAT + B_IN,  id: 3, exp: drv_b});
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_bit(name_of(sb[i].id), obs_of(sb[i].id), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int gap;
        @(negedge clk);

        // Reset state (rst held across two posedges).
        check_bit("rst_req_o", req_a, 1'b0);
        check_bit("rst_gnt_smp_o", gsmp_a, 1'b0);
        check_bit("rst_mismatch_o", mm_a, 1'b0);
        check_bit("rst_chk_vld_o", vld_a, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_bit("prime_chk_vld_lo", vld_a, 1'b0);
        step();
        check_bit("prime_chk_vld_hi", vld_a, 1'b1);

        // Single rising step on A at cycle 10.
        while (cyc < 10) step();
        drv_a = 1'b1;
        steps(5);
        check_bit("step_mismatch_o", mm_a, 1'b0);

        // Force A's gnt low for one cycle while req_o is steadily 1.
        steps(3);
        force_a = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].id == 1 && sb[i].due == cyc + A_IN) sb.delete(i);
        end
        sb.push_back('{due: cyc + A_IN, id: 1, exp: 1'b0});
        step();
        force_a = 1'b0;
        check_bit("force_mismatch_not_yet", mm_a, 1'b0);
        step();
        check_bit("force_mismatch_set", mm_a, 1'b1);
        steps(6);
        check_bit("force_mismatch_sticky", mm_a, 1'b1);
        check_cnt("force_err_cnt", err_a, STATS ? CW'(1) : CW'(0));

        // Mid-stream reset with req_o=1 and all stages full.
        drv_b = 1'b1;
        steps(8);
        rst   = 1'b1;
        drv_a = 1'b0;
        drv_b = 1'b0;
        sb.delete();
        step();
        check_bit("midrst_req_o", req_a, 1'b0);
        check_bit("midrst_gnt_smp_o", gsmp_a, 1'b0);
        check_bit("midrst_chk_vld_o", vld_a, 1'b0);
        check_bit("midrst_mismatch_o", mm_a, 1'b0);
        check_cnt("midrst_toggle_cnt", tog_a, CW'(0));
        check_cnt("midrst_err_cnt", err_a, CW'(0));
        check_bit("midrst_b_req_o", req_b, 1'b0);
        rst = 1'b0;
        step();
        check_bit("reprime_a_lo", vld_a, 1'b0);
        step();
        check_bit("reprime_a_hi", vld_a, 1'b1);
        check_bit("reprime_b_lo", vld_b, 1'b0);
        step();
        check_bit("reprime_b_hi", vld_b, 1'b1);

        // Ten toggles on A at random gaps (first two back-to-back).
        for (int t = 0; t < 10; t++) begin
            drv_a = ~drv_a;
            step();
            gap = (t == 0) ? 0 : int'($urandom_range(0, 15));
            steps(gap);
        end
        steps(8);
        check_bit("toggle_mismatch_o", mm_a, 1'b0);
        check_cnt("toggle_cnt", tog_a, STATS ? CW'(10) : CW'(0));
        check_cnt("toggle_err_cnt", err_a, CW'(0));

        // OUT_DLY=3 / IN_DLY=2 instance: single step, no mismatch.
        drv_b = 1'b1;
        steps(10);
        check_bit("b_mismatch_o", mm_b, 1'b0);
        check_cnt("b_err_cnt", err_b, CW'(0));

        // Drain remaining expectations.
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
